// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch front-panel controller: FSM state
// encodings, time-field widths and the time record carried between blocks.
package stopwatch_ctrl_pkg;

  localparam int HOURS_W   = 4;
  localparam int MINUTES_W = 6;
  localparam int SECONDS_W = 6;
  localparam int MS_W      = 10;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_LAP   = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  typedef enum logic [2:0] {
    S_INIT  = ST_INIT,
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_LAP   = ST_LAP,
    S_PAUSE = ST_PAUSE
  } state_t;

  typedef struct packed {
    logic [HOURS_W-1:0]   hours;
    logic [MINUTES_W-1:0] minutes;
    logic [SECONDS_W-1:0] seconds;
    logic [MS_W-1:0]      milliseconds;
  } time_t;

  // The counter runs in both the plain running state and while a lap is shown.
  function automatic logic runs_counter(input state_t s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stable-sample counter for one raw button;
// emits a single-cycle press on each accepted rising level.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  logic       sync_meta;
  logic       sync;
  logic       level;
  logic [7:0] count;
  logic       mismatch;
  logic       at_limit;

  assign mismatch = (sync != level);
  assign at_limit = (count == 8'(DEBOUNCE_CYCLES - 1));

  // Press is decoded from the sample that completes the stable run, so the
  // FSM consumes it on the same edge that flips the debounced level.
  assign press = mismatch && at_limit && sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      level     <= 1'b0;
      count     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values,
      // which is what makes the two synchroniser stages a real 2-FF chain.
      sync_meta <= raw;
      sync      <= sync_meta;
      if (!mismatch) begin
        count <= '0;
      end else if (at_limit) begin
        count <= '0;
        level <= sync;
      end else begin
        count <= count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: debounces the three buttons, runs the mode FSM,
// captures lap times and selects live or frozen time for the display.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned LAP_MAX         = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_start_stop,
  input  logic                 btn_lap,
  input  logic                 btn_clear,
  input  logic [HOURS_W-1:0]   hours,
  input  logic [MINUTES_W-1:0] minutes,
  input  logic [SECONDS_W-1:0] seconds,
  input  logic [MS_W-1:0]      milliseconds,
  output logic                 start_signal,
  output logic                 counter_clear,
  output logic [HOURS_W-1:0]   disp_hours,
  output logic [MINUTES_W-1:0] disp_minutes,
  output logic [SECONDS_W-1:0] disp_seconds,
  output logic [MS_W-1:0]      disp_milliseconds,
  output logic [3:0]           lap_count,
  output logic                 lap_valid
);

  state_t state;
  state_t next_state;
  logic   press_ss;
  logic   press_lap;
  logic   press_clr;
  logic   lap_take;
  logic   clear_take;
  time_t  live;
  time_t  lap_time;
  time_t  shown;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_start_stop),
    .press (press_ss)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_lap),
    .press (press_lap)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_clear),
    .press (press_clr)
  );

  assign live = {hours, minutes, seconds, milliseconds};

  // Priority clear > start_stop > lap falls out of the if/else order; a
  // losing press is simply dropped.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_state = state;
    lap_take   = 1'b0;
    clear_take = 1'b0;
    case (state)
      S_INIT: next_state = S_IDLE;
      S_IDLE: begin
        if (press_ss) next_state = S_RUN;
      end
      S_RUN, S_LAP: begin
        if (press_ss) begin
          next_state = S_PAUSE;
        end else if (press_lap) begin
          next_state = S_LAP;
          lap_take   = 1'b1;
        end
      end
      S_PAUSE: begin
        if (press_clr) begin
          next_state = S_IDLE;
          clear_take = 1'b1;
        end else if (press_ss) begin
          next_state = S_RUN;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_INIT;
      start_signal  <= 1'b0;
      counter_clear <= 1'b0;
      lap_time      <= '0;
      lap_count     <= '0;
      lap_valid     <= 1'b0;
    end else begin
      state         <= next_state;
      start_signal  <= runs_counter(next_state);
      // Registered so the pulse stays low while reset is held and fires for
      // exactly the first cycle after release.
      counter_clear <= (state == S_INIT) || clear_take;
      if (clear_take) begin
        lap_time  <= '0;
        lap_count <= '0;
        lap_valid <= 1'b0;
      end else if (lap_take) begin
        lap_time  <= live;
        lap_valid <= 1'b1;
        if (lap_count != 4'(LAP_MAX)) lap_count <= lap_count + 4'd1;
      end
    end
  end

  assign shown             = (state == S_LAP) ? lap_time : live;
  assign disp_hours        = shown.hours;
  assign disp_minutes      = shown.minutes;
  assign disp_seconds      = shown.seconds;
  assign disp_milliseconds = shown.milliseconds;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a behavioural model predicts the
// outputs each cycle into a queue that a negedge monitor drains and compares.
module tb_stopwatch_ctrl;

  localparam int D       = 4;
  localparam int LAP_MAX = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [9:0] milliseconds = '0;
  logic       start_signal;
  logic       counter_clear;
  logic [3:0] disp_hours;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic [9:0] disp_milliseconds;
  logic [3:0] lap_count;
  logic       lap_valid;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .LAP_MAX(LAP_MAX)) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_start_stop    (btn_ss),
    .btn_lap           (btn_lap),
    .btn_clear         (btn_clr),
    .hours             (hours),
    .minutes           (minutes),
    .seconds           (seconds),
    .milliseconds      (milliseconds),
    .start_signal      (start_signal),
    .counter_clear     (counter_clear),
    .disp_hours        (disp_hours),
    .disp_minutes      (disp_minutes),
    .disp_seconds      (disp_seconds),
    .disp_milliseconds (disp_milliseconds),
    .lap_count         (lap_count),
    .lap_valid         (lap_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cc_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {M_INIT, M_IDLE, M_RUN, M_LAP, M_PAUSE} mode_t;

  typedef struct {
    bit       start;
    bit       clr;
    int       laps;
    bit       valid;
    int       dh, dm, ds, dms;
  } exp_t;

  exp_t  q[$];
  mode_t m_mode;
  bit    raw_hist[3][$];
  bit    sync_win[3][$];
  bit    deb_level[3];
  int    m_laps;
  bit    m_valid;
  bit    m_start;
  bit    m_clr;
  int    lap_h, lap_m, lap_s, lap_ms;

  function automatic void model_reset();
    m_mode  = M_INIT;
    m_laps  = 0;
    m_valid = 0;
    m_start = 0;
    m_clr   = 0;
    lap_h = 0; lap_m = 0; lap_s = 0; lap_ms = 0;
    for (int b = 0; b < 3; b++) begin
      raw_hist[b].delete();
      raw_hist[b].push_back(1'b0);
      raw_hist[b].push_back(1'b0);
      sync_win[b].delete();
      deb_level[b] = 1'b0;
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.start = m_start;
    e.clr   = m_clr;
    e.laps  = m_laps;
    e.valid = m_valid;
    if (m_mode == M_LAP) begin
      e.dh = lap_h; e.dm = lap_m; e.ds = lap_s; e.dms = lap_ms;
    end else begin
      e.dh = int'(hours); e.dm = int'(minutes); e.ds = int'(seconds); e.dms = int'(milliseconds);
    end
    return e;
  endfunction

  // A button press is accepted when the raw level, seen two samples late,
  // has differed from the accepted level for D consecutive samples.
  always @(posedge clk) begin
    bit p[3];
    bit raw[3];
    bit all_diff;
    if (!reset) begin
      model_reset();
    end else begin
      raw[0] = btn_ss; raw[1] = btn_lap; raw[2] = btn_clr;
      for (int b = 0; b < 3; b++) begin
        p[b] = 1'b0;
        sync_win[b].push_back(raw_hist[b][0]);
        if (sync_win[b].size() > D) void'(sync_win[b].pop_front());
        all_diff = (sync_win[b].size() == D);
        foreach (sync_win[b][i]) if (sync_win[b][i] == deb_level[b]) all_diff = 1'b0;
        if (all_diff) begin
          deb_level[b] = ~deb_level[b];
          p[b] = deb_level[b];
          sync_win[b].delete();
        end
        raw_hist[b].push_back(raw[b]);
        void'(raw_hist[b].pop_front());
      end
      m_clr = 1'b0;
      case (m_mode)
        M_INIT: begin m_mode = M_IDLE; m_clr = 1'b1; end
        M_IDLE: if (p[0]) m_mode = M_RUN;
        M_RUN, M_LAP: begin
          if (p[0]) m_mode = M_PAUSE;
          else if (p[1]) begin
            m_mode = M_LAP;
            lap_h = int'(hours); lap_m = int'(minutes); lap_s = int'(seconds); lap_ms = int'(milliseconds);
            m_valid = 1'b1;
            if (m_laps < LAP_MAX) m_laps++;
          end
        end
        M_PAUSE: begin
          if (p[2]) begin
            m_mode = M_IDLE; m_clr = 1'b1;
            m_laps = 0; m_valid = 1'b0;
            lap_h = 0; lap_m = 0; lap_s = 0; lap_ms = 0;
          end else if (p[0]) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
      m_start = (m_mode == M_RUN) || (m_mode == M_LAP);
    end
    q.push_back(snapshot());
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (counter_clear === 1'b1) cc_seen++;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("start_signal", 32'(start_signal), 32'(e.start));
      check("counter_clear", 32'(counter_clear), 32'(e.clr));
      check("lap_count", 32'(lap_count), 32'(e.laps));
      check("lap_valid", 32'(lap_valid), 32'(e.valid));
      check("disp_time", {disp_hours, disp_minutes, disp_seconds, disp_milliseconds, 6'd0},
            {e.dh[3:0], e.dm[5:0], e.ds[5:0], e.dms[9:0], 6'd0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s, input int ms);
    hours = 4'(h); minutes = 6'(m); seconds = 6'(s); milliseconds = 10'(ms);
  endtask

  task automatic hold(input int which, input int n);
    if (which == 0) btn_ss = 1'b1;
    if (which == 1) btn_lap = 1'b1;
    if (which == 2) btn_clr = 1'b1;
    cyc(n);
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    cyc(D + 4);
  endtask

  initial begin
    int cc0;
    int run_left[3];
    bit lvl[3];

    cyc(3);
    reset = 1'b1;
    cyc(1);
    check("init_pulse_high", 32'(counter_clear), 32'd1);
    cyc(1);
    check("init_pulse_low", 32'(counter_clear), 32'd0);
    check("idle_start", 32'(start_signal), 32'd0);

    set_time(0, 1, 23, 456);
    btn_ss = 1'b1;
    cyc(5);
    check("start_before_cycle6", 32'(start_signal), 32'd0);
    cyc(1);
    check("start_at_cycle6", 32'(start_signal), 32'd1);
    cyc(4);
    btn_ss = 1'b0;
    cyc(D + 4);

    hold(1, 3);
    check("glitch_no_lap", 32'(lap_count), 32'd0);

    btn_lap = 1'b1;
    cyc(6);
    set_time(0, 1, 25, 789);
    cyc(2);
    btn_lap = 1'b0;
    cyc(D + 4);
    check("lap1_frozen_ms", 32'(disp_milliseconds), 32'd456);
    check("lap1_frozen_sec", 32'(disp_seconds), 32'd23);
    check("lap1_count", 32'(lap_count), 32'd1);
    check("lap1_valid", 32'(lap_valid), 32'd1);

    set_time(0, 2, 0, 0);
    hold(1, 8);
    check("lap2_minutes", 32'(disp_minutes), 32'd2);
    check("lap2_count", 32'(lap_count), 32'd2);

    set_time(1, 2, 3, 4);
    repeat (17) hold(1, 6);
    check("lap_saturate", 32'(lap_count), 32'd15);

    hold(0, 8);
    check("paused_start", 32'(start_signal), 32'd0);

    cc0 = cc_seen;
    btn_ss = 1'b1; btn_clr = 1'b1;
    cyc(8);
    btn_ss = 1'b0; btn_clr = 1'b0;
    cyc(D + 4);
    check("clear_wins_pulses", 32'(cc_seen - cc0), 32'd1);
    check("clear_wins_start", 32'(start_signal), 32'd0);
    check("clear_wins_laps", 32'(lap_count), 32'd0);
    check("clear_wins_valid", 32'(lap_valid), 32'd0);

    hold(0, 8);
    check("rerun_start", 32'(start_signal), 32'd1);
    cc0 = cc_seen;
    hold(2, 8);
    check("clear_ignored_run", 32'(cc_seen - cc0), 32'd0);
    check("still_running", 32'(start_signal), 32'd1);

    set_time(3, 4, 5, 6);
    hold(1, 8);
    set_time(3, 4, 6, 7);
    reset = 1'b0;
    #1;
    check("async_rst_start", 32'(start_signal), 32'd0);
    check("async_rst_laps", 32'(lap_count), 32'd0);
    check("async_rst_valid", 32'(lap_valid), 32'd0);
    check("async_rst_clear", 32'(counter_clear), 32'd0);
    check("async_rst_disp", 32'(disp_seconds), 32'd6);
    cc0 = cc_seen;
    cyc(2);
    reset = 1'b1;
    cyc(3);
    check("post_rst_init_pulse", 32'(cc_seen - cc0), 32'd1);
    check("post_rst_idle", 32'(start_signal), 32'd0);

    for (int b = 0; b < 3; b++) begin
      run_left[b] = 0;
      lvl[b] = 1'b0;
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_time($urandom_range(0, 15), $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 999));
      for (int b = 0; b < 3; b++) begin
        if (run_left[b] == 0) begin
          lvl[b] = ($urandom_range(0, 9) < ((b == 2) ? 2 : 4));
          run_left[b] = $urandom_range(1, 10);
        end
        run_left[b]--;
      end
      btn_ss = lvl[0]; btn_lap = lvl[1]; btn_clr = lvl[2];
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
      end
      cyc(1);
    end
    btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
    cyc(D + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
